rec_data_sequencer: RTL and testbench
=====================================

// Module: rec_data_sequencer
// PURPOSE
//  Consumer of flight-mode rec_data_sel; sits between the receiver and angle_controller.
//  Routes live stick values (pass-through) or generates synthetic throttle/attitude
//  commands for auto take-off, hover and auto-land. Throttle ramps at a fixed rate, with no step jumps.
// PARAMETERS
//  THR_MIN        8'd0     throttle floor / motors-off value (= `MOTOR_VAL_MIN)
//  HOVER_THR      8'd100   hover throttle target (= `HOVER_THROTTLE_VAL)
//  STICK_CENTER   8'd128   neutral yaw/roll/pitch value
//  RAMP_STEP      8'd1     throttle increment/decrement per ramp tick
//  RAMP_PERIOD_US 20000    us_clk cycles between ramp ticks (1 us clock)
// PORTS
//  us_clk                 in   1  1 MHz system clock
//  machxo3_switch_reset_n in   1  async active-low reset
//  rec_data_sel           in   3  `REC_DATA_SEL_BIT_WIDTH mode select from flight_mode
//  throttle_in/yaw_in/roll_in/pitch_in  in  8 each  receiver channel values
//  throttle_out/yaw_out/roll_out/pitch_out  out 8 each  registered commands to angle_controller
//  at_target              out  1  auto-mode throttle equals its target (THR_MIN or HOVER_THR)
//  cur_state              out  3  state encoding, debug LEDs
// BEHAVIOUR
//  Reset: throttle_out=THR_MIN; yaw/roll/pitch_out=STICK_CENTER; at_target=1;
//   state=S_OFF; tick counter=0.
//  Select codes: OFF=0, PASS_THROUGH=1, AUTO_TAKE_OFF=2, AUTO_LAND=3, HOVER=4.
//   Codes 5-7 are illegal and are treated as AUTO_LAND (fail-safe).
//  State register: next state is decoded from rec_data_sel every clock. No other transition conditions.
//   S_OFF,S_PASS,S_TAKEOFF,S_LAND,S_HOVER = 0..4.
//  Outputs are registered. Latency from an input/select change to the outputs is 1 cycle.
//  S_OFF:     throttle_out<=THR_MIN immediately; attitude<=STICK_CENTER.
//  S_PASS:    all four outputs <= the *_in values (1-cycle registered copy).
//  S_TAKEOFF: attitude<=STICK_CENTER; on each tick, throttle moves toward HOVER_THR by RAMP_STEP.
//  S_LAND:    attitude<=STICK_CENTER; on each tick, throttle moves toward THR_MIN by RAMP_STEP.
//  S_HOVER:   attitude<=STICK_CENTER; throttle ramps toward HOVER_THR, same rule as take-off.
//  Ramp arithmetic: 9-bit compare against the target, then saturate. The step never overshoots:
//   if |target-throttle_out| < RAMP_STEP, then throttle_out<=target. No 8-bit wrap, ever.
//  Tick: 15-bit counter counts 0..RAMP_PERIOD_US-1 and issues a 1-cycle tick on wrap.
//   The counter clears to 0 on any state change, so the first step after entry comes a full period later.
//   The counter free-runs in S_OFF/S_PASS, where it is unused.
//  Mid-ramp mode change: the new ramp starts from the current throttle_out (no jump).
//   PASS->auto continues from the last pass-through throttle.
//  at_target: combinational from registered values. It is 1 when throttle_out equals the
//   state's target; it is forced to 1 in S_OFF and 0 in S_PASS.
//  Simultaneous tick and state change: the state change wins. No step is applied that cycle; the counter clears.
//  Reset asserted mid-ramp: all outputs return to reset values asynchronously.
// STRUCTURE
//  common_defines.v: REC_DATA_SEL_BIT_WIDTH=3, the REC_SEL_* codes,
//   MOTOR_VAL_MIN, HOVER_THROTTLE_VAL, STICK_CENTER.
//  One sub-module, ramp_tick_gen (parameterised prescaler with sync clear and tick out).
//   The ramp/saturate logic stays inline.
// TESTING
//  1. Reset, sel=OFF, throttle_in=200 -> throttle_out=0, attitude outs=128, at_target=1.
//  2. sel=PASS, inputs 150/10/20/30 -> outputs match on the next clock edge.
//  3. sel=TAKE_OFF from throttle 0, RAMP_PERIOD_US=4 (test param) -> +1 every 4 clocks.
//     At 100, throttle holds and at_target=1.
//  4. sel=AUTO_LAND from 3, RAMP_STEP=2 -> 3,1,0 then holds at 0. No wrap to 255.
//  5. PASS at throttle 180 -> HOVER -> first step after 4 clocks gives 179, decreasing to 100.
//     Mid-way, switch to LAND -> continues downward from the current value.
//  6. sel=7 -> behaves as LAND. Reset pulse mid-ramp -> outputs reset values within the same cycle.

Source files
------------

// File: rtl/rec_data_sequencer_pkg.sv
// Shared select codes, command constants and ramp helpers for the receiver-data sequencer.
// Consumers import this package rather than using preprocessor defines.
package rec_data_sequencer_pkg;

  localparam int          REC_DATA_SEL_BIT_WIDTH = 3;
  localparam logic [2:0]  REC_SEL_OFF            = 3'd0;
  localparam logic [2:0]  REC_SEL_PASS_THROUGH   = 3'd1;
  localparam logic [2:0]  REC_SEL_AUTO_TAKE_OFF  = 3'd2;
  localparam logic [2:0]  REC_SEL_AUTO_LAND      = 3'd3;
  localparam logic [2:0]  REC_SEL_HOVER          = 3'd4;

  localparam logic [7:0]  MOTOR_VAL_MIN          = 8'd0;
  localparam logic [7:0]  HOVER_THROTTLE_VAL     = 8'd100;
  localparam logic [7:0]  STICK_CENTER_VAL       = 8'd128;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_PASS    = 3'd1,
    S_TAKEOFF = 3'd2,
    S_LAND    = 3'd3,
    S_HOVER   = 3'd4
  } seq_state_t;

  // Unknown codes fall back to landing so a corrupted select never leaves motors running.
  function automatic seq_state_t decode_sel(input logic [REC_DATA_SEL_BIT_WIDTH-1:0] sel);
    case (sel)
      REC_SEL_OFF:           return S_OFF;
      REC_SEL_PASS_THROUGH:  return S_PASS;
      REC_SEL_AUTO_TAKE_OFF: return S_TAKEOFF;
      REC_SEL_AUTO_LAND:     return S_LAND;
      REC_SEL_HOVER:         return S_HOVER;
      default:               return S_LAND;
    endcase
  endfunction

  // One saturating step toward tgt; 9-bit math so the result can neither overshoot nor wrap.
  function automatic logic [7:0] ramp_toward(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [7:0] step);
    logic [8:0] c, t, s, d, r;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    s = {1'b0, step};
    r = c;
    if (c < t) begin
      d = t - c;
      r = (d <= s) ? t : c + s;
    end else if (c > t) begin
      d = c - t;
      r = (d <= s) ? t : c - s;
    end
    return r[7:0];
  endfunction

endpackage

// File: rtl/rec_data_sequencer_ramp_tick_gen.sv
// Prescaler producing a one-cycle tick every PERIOD clocks; a synchronous clear
// restarts the count so the next tick lands a full period later.
module ramp_tick_gen #(
  parameter int PERIOD = 20000,
  parameter int WIDTH  = 15
) (
  input  logic us_clk,
  input  logic machxo3_switch_reset_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);

  logic [WIDTH-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign o_tick = w_wrap;

  always_ff @(posedge us_clk or negedge machxo3_switch_reset_n) begin
    if (!machxo3_switch_reset_n)
      r_cnt <= '0;
    else if (i_clr || w_wrap)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/rec_data_sequencer.sv
// Routes live stick values or synthesises ramped throttle / centred attitude
// commands for auto take-off, hover and landing, ahead of the angle controller.
module rec_data_sequencer
  import rec_data_sequencer_pkg::*;
#(
  parameter logic [7:0] THR_MIN        = MOTOR_VAL_MIN,
  parameter logic [7:0] HOVER_THR      = HOVER_THROTTLE_VAL,
  parameter logic [7:0] STICK_CENTER   = STICK_CENTER_VAL,
  parameter logic [7:0] RAMP_STEP      = 8'd1,
  parameter int         RAMP_PERIOD_US = 20000
) (
  input  logic                              us_clk,
  input  logic                              machxo3_switch_reset_n,
  input  logic [REC_DATA_SEL_BIT_WIDTH-1:0] rec_data_sel,
  input  logic [7:0]                        throttle_in,
  input  logic [7:0]                        yaw_in,
  input  logic [7:0]                        roll_in,
  input  logic [7:0]                        pitch_in,
  output logic [7:0]                        throttle_out,
  output logic [7:0]                        yaw_out,
  output logic [7:0]                        roll_out,
  output logic [7:0]                        pitch_out,
  output logic                              at_target,
  output logic [2:0]                        cur_state
);

  seq_state_t r_state;
  seq_state_t w_state_next;
  logic       w_state_change;
  logic       w_tick;
  logic [7:0] w_target;
  logic [7:0] r_throttle, r_yaw, r_roll, r_pitch;
  logic [7:0] w_throttle_next, w_yaw_next, w_roll_next, w_pitch_next;

  ramp_tick_gen #(
    .PERIOD (RAMP_PERIOD_US),
    .WIDTH  (15)
  ) u_ramp_tick_gen (
    .us_clk                 (us_clk),
    .machxo3_switch_reset_n (machxo3_switch_reset_n),
    .i_clr                  (w_state_change),
    .o_tick                 (w_tick)
  );

  always_ff @(posedge us_clk or negedge machxo3_switch_reset_n) begin
    if (!machxo3_switch_reset_n) begin
      r_state    <= S_OFF;
      r_throttle <= THR_MIN;
      r_yaw      <= STICK_CENTER;
      r_roll     <= STICK_CENTER;
      r_pitch    <= STICK_CENTER;
    end else begin
      r_state    <= w_state_next;
      r_throttle <= w_throttle_next;
      r_yaw      <= w_yaw_next;
      r_roll     <= w_roll_next;
      r_pitch    <= w_pitch_next;
    end
  end

  // Outputs follow the incoming state so a select change reaches them one edge later.
  always_comb begin
    w_state_next    = decode_sel(rec_data_sel);
    w_state_change  = (w_state_next != r_state);
    w_target        = (w_state_next == S_LAND) ? THR_MIN : HOVER_THR;
    w_throttle_next = r_throttle;
    w_yaw_next      = STICK_CENTER;
    w_roll_next     = STICK_CENTER;
    w_pitch_next    = STICK_CENTER;
    case (w_state_next)
      S_OFF: w_throttle_next = THR_MIN;
      S_PASS: begin
        w_throttle_next = throttle_in;
        w_yaw_next      = yaw_in;
        w_roll_next     = roll_in;
        w_pitch_next    = pitch_in;
      end
      default: begin
        // A tick coinciding with a state change is dropped; the new ramp restarts its period.
        if (w_tick && !w_state_change)
          w_throttle_next = ramp_toward(r_throttle, w_target, RAMP_STEP);
      end
    endcase
  end

  always_comb begin
    at_target = 1'b1;
    case (r_state)
      S_OFF:   at_target = 1'b1;
      S_PASS:  at_target = 1'b0;
      S_LAND:  at_target = (r_throttle == THR_MIN);
      default: at_target = (r_throttle == HOVER_THR);
    endcase
  end

  assign throttle_out = r_throttle;
  assign yaw_out      = r_yaw;
  assign roll_out     = r_roll;
  assign pitch_out    = r_pitch;
  assign cur_state    = r_state;

endmodule

// File: tb/tb_rec_data_sequencer.sv
// Directed bench for rec_data_sequencer: a step-1 and a step-2 instance share
// stimulus, both with a 4-cycle ramp period so ramps are short.
module tb_rec_data_sequencer;

  logic       clk;
  logic       rst_n;
  logic [2:0] sel;
  logic [7:0] thr_in, yaw_in, roll_in, pitch_in;

  logic [7:0] a_thr, a_yaw, a_roll, a_pitch;
  logic       a_at;
  logic [2:0] a_st;
  logic [7:0] b_thr, b_yaw, b_roll, b_pitch;
  logic       b_at;
  logic [2:0] b_st;

  int checks = 0;
  int errors = 0;

  rec_data_sequencer #(.RAMP_STEP(8'd1), .RAMP_PERIOD_US(4)) dut_a (
    .us_clk(clk), .machxo3_switch_reset_n(rst_n), .rec_data_sel(sel),
    .throttle_in(thr_in), .yaw_in(yaw_in), .roll_in(roll_in), .pitch_in(pitch_in),
    .throttle_out(a_thr), .yaw_out(a_yaw), .roll_out(a_roll), .pitch_out(a_pitch),
    .at_target(a_at), .cur_state(a_st)
  );

  rec_data_sequencer #(.RAMP_STEP(8'd2), .RAMP_PERIOD_US(4)) dut_b (
    .us_clk(clk), .machxo3_switch_reset_n(rst_n), .rec_data_sel(sel),
    .throttle_in(thr_in), .yaw_in(yaw_in), .roll_in(roll_in), .pitch_in(pitch_in),
    .throttle_out(b_thr), .yaw_out(b_yaw), .roll_out(b_roll), .pitch_out(b_pitch),
    .at_target(b_at), .cur_state(b_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle on the falling edge for sampling/driving.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; sel = 3'd0;
    thr_in = 8'd200; yaw_in = 8'd0; roll_in = 8'd0; pitch_in = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_thr", a_thr, 8'd0);
    chk("rst_at", {7'd0, a_at}, 8'd1);
    rst_n = 1'b1;
    cyc(2);
    // 1: OFF ignores throttle_in
    chk("off_thr", a_thr, 8'd0);
    chk("off_yaw", a_yaw, 8'd128);
    chk("off_roll", a_roll, 8'd128);
    chk("off_pitch", a_pitch, 8'd128);
    chk("off_at", {7'd0, a_at}, 8'd1);
    chk("off_state", {5'd0, a_st}, 8'd0);

    // 2: pass-through, one-cycle latency
    sel = 3'd1; thr_in = 8'd150; yaw_in = 8'd10; roll_in = 8'd20; pitch_in = 8'd30;
    cyc(1);
    chk("pass_thr", a_thr, 8'd150);
    chk("pass_yaw", a_yaw, 8'd10);
    chk("pass_roll", a_roll, 8'd20);
    chk("pass_pitch", a_pitch, 8'd30);
    chk("pass_at", {7'd0, a_at}, 8'd0);
    chk("pass_state", {5'd0, a_st}, 8'd1);

    // 3: take-off from 0, +1 every 4 clocks, holds at 100
    sel = 3'd0; cyc(1);
    chk("off_again_thr", a_thr, 8'd0);
    sel = 3'd2; cyc(1);
    chk("to_entry_thr", a_thr, 8'd0);
    chk("to_state", {5'd0, a_st}, 8'd2);
    chk("to_yaw_center", a_yaw, 8'd128);
    chk("to_at_entry", {7'd0, a_at}, 8'd0);
    cyc(3);  chk("to_p3", a_thr, 8'd0);
    cyc(1);  chk("to_p4", a_thr, 8'd1);
    cyc(4);  chk("to_p8", a_thr, 8'd2);
    cyc(391); chk("to_p399", a_thr, 8'd99);
    chk("to_at_p399", {7'd0, a_at}, 8'd0);
    cyc(1);  chk("to_p400", a_thr, 8'd100);
    chk("to_at_p400", {7'd0, a_at}, 8'd1);
    cyc(20); chk("to_hold", a_thr, 8'd100);
    chk("to_hold_at", {7'd0, a_at}, 8'd1);

    // 4: landing from 3 with step 2 saturates at 0
    sel = 3'd1; thr_in = 8'd3; cyc(1);
    chk("b_pass3", b_thr, 8'd3);
    sel = 3'd3; cyc(1);
    chk("b_land_entry", b_thr, 8'd3);
    chk("b_land_state", {5'd0, b_st}, 8'd3);
    cyc(4);
    chk("b_land_1", b_thr, 8'd1);
    chk("a_land_2", a_thr, 8'd2);
    cyc(4);
    chk("b_land_0", b_thr, 8'd0);
    chk("b_land_at", {7'd0, b_at}, 8'd1);
    cyc(8);
    chk("b_land_nowrap", b_thr, 8'd0);

    // 5: hover from 180 ramps down, then land continues from current value
    sel = 3'd1; thr_in = 8'd180; cyc(1);
    chk("pass180", a_thr, 8'd180);
    sel = 3'd4; cyc(1);
    chk("hov_entry", a_thr, 8'd180);
    chk("hov_state", {5'd0, a_st}, 8'd4);
    cyc(3);  chk("hov_p3", a_thr, 8'd180);
    cyc(1);  chk("hov_p4", a_thr, 8'd179);
    cyc(36); chk("hov_p40", a_thr, 8'd170);
    sel = 3'd3; cyc(1);
    chk("hl_entry", a_thr, 8'd170);
    chk("hl_state", {5'd0, a_st}, 8'd3);
    cyc(3);  chk("hl_p3", a_thr, 8'd170);
    cyc(1);  chk("hl_p4", a_thr, 8'd169);

    // 6: illegal code 7 acts as land; tick coinciding with a state change is dropped
    sel = 3'd1; thr_in = 8'd50; cyc(1);
    chk("pass50", a_thr, 8'd50);
    chk("pass50_yaw", a_yaw, 8'd10);
    sel = 3'd7; cyc(1);
    chk("sel7_state", {5'd0, a_st}, 8'd3);
    chk("sel7_thr", a_thr, 8'd50);
    chk("sel7_yaw", a_yaw, 8'd128);
    cyc(4);  chk("sel7_p4", a_thr, 8'd49);
    chk("sel7_at", {7'd0, a_at}, 8'd0);
    cyc(3);  chk("sel7_p7", a_thr, 8'd49);
    sel = 3'd2; cyc(1);
    chk("coinc_thr", a_thr, 8'd49);
    chk("coinc_state", {5'd0, a_st}, 8'd2);
    cyc(3);  chk("coinc_p3", a_thr, 8'd49);
    cyc(1);  chk("coinc_p4", a_thr, 8'd50);

    // Asynchronous reset mid-ramp, observed before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("arst_thr", a_thr, 8'd0);
    chk("arst_yaw", a_yaw, 8'd128);
    chk("arst_state", {5'd0, a_st}, 8'd0);
    chk("arst_at", {7'd0, a_at}, 8'd1);
    chk("arst_b_thr", b_thr, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
